// File: rtl/out_sig_pkg.sv
// ---------------------------------------------------------------------------
// out_sig_pkg
// Shared definitions for the output-signature collector:
//   - default signature width, MISR polynomial and seed
//   - collector state enum (IDLE, RUN, DONE)
//   - misr_step: one MISR shift/feedback/inject step
// No ports (package).
// ---------------------------------------------------------------------------
package out_sig_pkg;

  localparam int          SIG_W_DEF  = 32;
  localparam logic [31:0] POLY_DEF   = 32'h04C11DB7;
  localparam logic [31:0] SEED_DEF   = 32'hFFFFFFFF;

  // Widest signature misr_step can handle; narrower signatures are
  // zero-extended into this width and masked back down.
  localparam int          SIG_W_MAX  = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // One MISR step for a signature of 'width' bits held in the low bits of
  // a SIG_W_MAX container: shift left, feed back the polynomial when the
  // outgoing MSB is set, then inject the folded sample.
  function automatic logic [SIG_W_MAX-1:0] misr_step(
    input logic [SIG_W_MAX-1:0] sig,
    input logic [SIG_W_MAX-1:0] poly,
    input logic [SIG_W_MAX-1:0] fold,
    input int                   width
  );
    logic [SIG_W_MAX-1:0] mask;
    logic [SIG_W_MAX-1:0] next;
    logic                 msb;
    if (width >= SIG_W_MAX) begin
      mask = '1;
    end else begin
      mask = (SIG_W_MAX'(1) << width) - SIG_W_MAX'(1);
    end
    msb  = |(sig & (SIG_W_MAX'(1) << (width - 1)));
    next = (sig << 1) & mask;
    if (msb) begin
      next = next ^ poly;
    end
    next = next ^ fold;
    return next & mask;
  endfunction

endpackage

// File: rtl/sig_fold.sv
// ---------------------------------------------------------------------------
// sig_fold
// Purely combinational XOR folder. Splits i_data into ceil(DATA_W/SIG_W)
// SIG_W-bit chunks starting at bit 0 (top chunk zero-extended) and XORs
// all chunks together.
// Ports:
//   i_data  in  DATA_W  bus to fold
//   o_fold  out SIG_W   XOR of all chunks
// ---------------------------------------------------------------------------
module sig_fold #(
  parameter int DATA_W = 330,
  parameter int SIG_W  = 32
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [SIG_W-1:0]  o_fold
);

  localparam int NUM_CHUNKS = (DATA_W + SIG_W - 1) / SIG_W;
  localparam int PAD_W      = NUM_CHUNKS * SIG_W;

  logic [PAD_W-1:0] w_padded;
  logic [SIG_W-1:0] w_fold;

  // The cast zero-extends, which gives the top chunk its zero padding.
  assign w_padded = PAD_W'(i_data);

  // XOR every chunk into one signature-wide word.
  always_comb begin
    w_fold = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      w_fold = w_fold ^ w_padded[k*SIG_W +: SIG_W];
    end
  end

  assign o_fold = w_fold;

endmodule

// File: rtl/out_sig_collector.sv
// ---------------------------------------------------------------------------
// out_sig_collector
// Samples a DUT output bus on each valid cycle and compacts it into a MISR
// signature; hands the final signature and sample count to the harness via
// a sig_valid/sig_ready handshake.
// Ports:
//   clk          in  1       clock, rising edge
//   rst_n        in  1       asynchronous active-low reset
//   start        in  1       begin a run (only honoured in IDLE)
//   num_samples  in  32      samples to collect, captured on start
//   in_valid     in  1       in_data valid this cycle
//   in_data      in  DATA_W  sampled output bus
//   busy         out 1       high while collecting (RUN)
//   sig_valid    out 1       final signature available (DONE)
//   sig_ready    in  1       consumer accepts the signature
//   signature    out SIG_W   running / final MISR value
//   sample_count out 32      samples accepted in the current run
// ---------------------------------------------------------------------------
module out_sig_collector
  import out_sig_pkg::*;
#(
  parameter int               DATA_W = 330,
  parameter int               SIG_W  = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(SEED_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       num_samples,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              sig_valid,
  input  logic              sig_ready,
  output logic [SIG_W-1:0]  signature,
  output logic [31:0]       sample_count
);

  state_t            r_state;
  logic [SIG_W-1:0]  r_sig;
  logic [31:0]       r_count;
  logic [31:0]       r_target;
  logic              r_busy;
  logic              r_sig_valid;

  state_t            w_state_next;
  logic [SIG_W-1:0]  w_sig_next;
  logic [31:0]       w_count_next;
  logic [31:0]       w_target_next;
  logic [31:0]       w_count_inc;
  logic [SIG_W-1:0]  w_fold;
  logic [SIG_W-1:0]  w_step;

  sig_fold #(
    .DATA_W (DATA_W),
    .SIG_W  (SIG_W)
  ) u_fold (
    .i_data (in_data),
    .o_fold (w_fold)
  );

  assign w_step = SIG_W'(misr_step(SIG_W_MAX'(r_sig), SIG_W_MAX'(POLY),
                                   SIG_W_MAX'(w_fold), SIG_W));

  assign w_count_inc = r_count + 32'd1;

  // Next-state logic. Everything holds by default; only an accepted start
  // in IDLE or an accepted sample in RUN touches the datapath, so DONE and
  // the following IDLE keep the final signature and count visible.
  always_comb begin
    w_state_next  = r_state;
    w_sig_next    = r_sig;
    w_count_next  = r_count;
    w_target_next = r_target;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_sig_next    = SEED;
          w_count_next  = '0;
          w_target_next = num_samples;
          w_state_next  = (num_samples == 32'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          w_sig_next   = w_step;
          w_count_next = w_count_inc;
          if (w_count_inc == r_target) begin
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        if (sig_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers. busy and sig_valid are registered from
  // the next state so they line up with the state they describe, and
  // sig_valid rises together with the last sample's signature update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sig       <= SEED;
      r_count     <= '0;
      r_target    <= '0;
      r_busy      <= 1'b0;
      r_sig_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_sig       <= w_sig_next;
      r_count     <= w_count_next;
      r_target    <= w_target_next;
      r_busy      <= (w_state_next == RUN);
      r_sig_valid <= (w_state_next == DONE);
    end
  end

  assign busy         = r_busy;
  assign sig_valid    = r_sig_valid;
  assign signature    = r_sig;
  assign sample_count = r_count;

endmodule

// File: tb/tb_out_sig_collector.sv
// ---------------------------------------------------------------------------
// tb_out_sig_collector
// Directed bench for out_sig_collector with an independent bit-level MISR
// model; expected results are queued as stimulus is driven and popped when
// the collector presents its signature.
// ---------------------------------------------------------------------------
module tb_out_sig_collector;

  localparam int          DATA_W = 330;
  localparam logic [31:0] POLY   = 32'h04C11DB7;
  localparam logic [31:0] SEED   = 32'hFFFFFFFF;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [31:0]       num_samples;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              busy;
  logic              sig_valid;
  logic              sig_ready;
  logic [31:0]       signature;
  logic [31:0]       sample_count;

  typedef struct {
    logic [31:0] sig;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sbq[$];
  exp_t        lastExp;
  logic [31:0] modelSig;
  logic [31:0] modelCount;
  logic [31:0] modelTarget;
  int          checkCount;
  int          failCount;

  out_sig_collector #(
    .DATA_W (DATA_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_samples  (num_samples),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .busy         (busy),
    .sig_valid    (sig_valid),
    .sig_ready    (sig_ready),
    .signature    (signature),
    .sample_count (sample_count)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference MISR step built bit by bit: bit i of the bus lands on
  // signature bit i mod 32.
  function automatic logic [31:0] modelStep(input logic [31:0] s,
                                            input logic [DATA_W-1:0] d);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < DATA_W; i++) begin
      f[i % 32] = f[i % 32] ^ d[i];
    end
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  function automatic logic [DATA_W-1:0] randData();
    logic [351:0] t;
    for (int k = 0; k < 11; k++) begin
      t[k*32 +: 32] = $urandom;
    end
    return t[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] oneBit(input int idx);
    logic [DATA_W-1:0] d;
    d      = '0;
    d[idx] = 1'b1;
    return d;
  endfunction

  // Advance one clock; inputs change and outputs are read 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulse start for one cycle and prime the model for the new run.
  task automatic applyStimulus(input logic [31:0] n);
    start       = 1'b1;
    num_samples = n;
    modelSig    = SEED;
    modelCount  = '0;
    modelTarget = n;
    if (n == 32'd0) begin
      sbq.push_back('{sig: SEED, cnt: 32'd0});
    end
    tick();
    start = 1'b0;
  endtask

  // Present one valid sample; queue the expectation once the run completes.
  task automatic sendSample(input logic [DATA_W-1:0] d);
    in_valid   = 1'b1;
    in_data    = d;
    modelSig   = modelStep(modelSig, d);
    modelCount = modelCount + 32'd1;
    if (modelCount == modelTarget) begin
      sbq.push_back('{sig: modelSig, cnt: modelCount});
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Bounded wait for sig_valid, then compare against the queued expectation.
  task automatic waitSignature(input string tag);
    int cycles;
    cycles = 0;
    while (sig_valid !== 1'b1 && cycles < 50) begin
      tick();
      cycles++;
    end
    checkOutput({tag, "_sig_valid"}, 64'(sig_valid), 64'(1'b1));
    if (sbq.size() == 0) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      lastExp = sbq.pop_front();
      checkOutput({tag, "_signature"}, 64'(signature), 64'(lastExp.sig));
      checkOutput({tag, "_count"}, 64'(sample_count), 64'(lastExp.cnt));
    end
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    checkCount  = 0;
    failCount   = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    num_samples = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    sig_ready   = 1'b1;
    modelSig    = SEED;
    modelCount  = '0;
    modelTarget = '0;

    // Reset state
    tick();
    tick();
    checkOutput("reset_signature", 64'(signature), 64'(SEED));
    checkOutput("reset_count", 64'(sample_count), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_sig_valid", 64'(sig_valid), 64'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("idle_busy", 64'(busy), 64'd0);

    // Zero-length run: DONE straight from IDLE, sig_valid for one cycle
    applyStimulus(32'd0);
    checkOutput("zero_busy", 64'(busy), 64'd0);
    waitSignature("zero");
    checkOutput("zero_sig_const", 64'(signature), 64'hFFFFFFFF);
    tick();
    checkOutput("zero_valid_drop", 64'(sig_valid), 64'd0);

    // Single zero sample
    applyStimulus(32'd1);
    checkOutput("single_busy", 64'(busy), 64'd1);
    checkOutput("single_valid_early", 64'(sig_valid), 64'd0);
    sendSample('0);
    checkOutput("single_valid_latency", 64'(sig_valid), 64'd1);
    waitSignature("single");
    checkOutput("single_sig_const", 64'(signature), 64'hFB3EE249);
    tick();
    checkOutput("single_release", 64'(sig_valid), 64'd0);
    checkOutput("single_hold_after", 64'(signature), 64'hFB3EE249);

    // Fold coverage
    applyStimulus(32'd1);
    sendSample(oneBit(0));
    waitSignature("fold_b0");
    checkOutput("fold_b0_const", 64'(signature), 64'hFB3EE248);
    tick();
    applyStimulus(32'd1);
    sendSample(oneBit(32));
    waitSignature("fold_b32");
    checkOutput("fold_b32_const", 64'(signature), 64'hFB3EE248);
    tick();
    applyStimulus(32'd1);
    sendSample(oneBit(329));
    waitSignature("fold_b329");
    checkOutput("fold_b329_const", 64'(signature), 64'hFB3EE049);
    tick();

    // Gaps with a start pulse mid-run that must be ignored
    applyStimulus(32'd2);
    sendSample('0);
    checkOutput("gap_count1", 64'(sample_count), 64'd1);
    tick();
    start       = 1'b1;
    num_samples = 32'd7;
    tick();
    start = 1'b0;
    checkOutput("gap_no_restart_count", 64'(sample_count), 64'd1);
    checkOutput("gap_busy", 64'(busy), 64'd1);
    sendSample('0);
    waitSignature("gap");
    checkOutput("gap_sig_const", 64'(signature), 64'hF2BCD925);
    tick();

    // Backpressure in DONE with noise on every other input
    sig_ready = 1'b0;
    applyStimulus(32'd3);
    for (int i = 0; i < 3; i++) begin
      sendSample(randData());
    end
    waitSignature("bp");
    for (int i = 0; i < 5; i++) begin
      in_valid    = i[0];
      in_data     = randData();
      start       = (i == 2);
      num_samples = 32'd4;
      tick();
      checkOutput($sformatf("bp_hold_sig_%0d", i), 64'(signature), 64'(lastExp.sig));
      checkOutput($sformatf("bp_hold_cnt_%0d", i), 64'(sample_count), 64'(lastExp.cnt));
      checkOutput($sformatf("bp_hold_valid_%0d", i), 64'(sig_valid), 64'd1);
    end
    in_valid  = 1'b0;
    sig_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("bp_release_valid", 64'(sig_valid), 64'd0);
    checkOutput("bp_release_busy", 64'(busy), 64'd0);
    checkOutput("bp_release_sig", 64'(signature), 64'(lastExp.sig));
    tick();
    checkOutput("bp_start_ignored", 64'(busy), 64'd0);
    checkOutput("bp_count_held", 64'(sample_count), 64'(lastExp.cnt));

    // Reset in the middle of a 10-sample run
    applyStimulus(32'd10);
    for (int i = 0; i < 3; i++) begin
      sendSample(randData());
    end
    checkOutput("midrst_pre_count", 64'(sample_count), 64'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_signature", 64'(signature), 64'(SEED));
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_count", 64'(sample_count), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(32'd1);
    sendSample('0);
    waitSignature("post_rst");
    checkOutput("post_rst_const", 64'(signature), 64'hFB3EE249);
    tick();

    // Longer random run with irregular gaps
    applyStimulus(32'd6);
    for (int i = 0; i < 6; i++) begin
      d = randData();
      sendSample(d);
      if (i % 2 == 0) begin
        tick();
      end
    end
    waitSignature("random6");
    tick();
    checkOutput("random6_release", 64'(sig_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
